// File: rtl/ripple_count_checker_pkg.sv
// rtl/ripple_count_checker_pkg.sv - shared state encoding, direction codes and default widths
package ripple_count_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_UP    = 2'd2,
    ST_DOWN  = 2'd3
  } state_t;

  localparam logic [1:0] DIR_UNK  = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STABLE = 2;
  localparam int DEF_WRAPW  = 8;
  localparam int DEF_ERRW   = 8;

endpackage

// File: rtl/count_sync_filter.sv
// rtl/count_sync_filter.sv - two-flop synchronizer with a stability window on the synchronized count
module count_sync_filter
  import ripple_count_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STABLE = DEF_STABLE
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] s2_next,
  output logic             stable_hit
);

  localparam int KW = $clog2(STABLE + 1);

  logic [WIDTH-1:0] s1, s2;
  logic [KW-1:0]    k, k_next;

  // s2_next is the value s2 takes at this edge; it is the acceptance candidate
  always_comb begin
    s2_next = s1;
    if (s1 != s2)
      k_next = KW'(1);
    else if (k == KW'(STABLE))
      k_next = k;
    else
      k_next = k + 1'b1;
    stable_hit = (k_next == KW'(STABLE));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      s1 <= '0;
      s2 <= '0;
      k  <= '0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      k  <= k_next;
    end
  end

endmodule

// File: rtl/ripple_count_checker.sv
// rtl/ripple_count_checker.sv - validates a synchronized ripple count: direction, wraps and illegal steps
module ripple_count_checker
  import ripple_count_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STABLE = DEF_STABLE,
  parameter int WRAPW  = DEF_WRAPW,
  parameter int ERRW   = DEF_ERRW
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic [1:0]       dir,
  output logic             step_err,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic [ERRW-1:0]  err_cnt
);

  state_t           state, state_n;
  logic [WIDTH-1:0] cand, value_n, delta;
  logic             stable_hit, accept, is_up, is_dn;
  logic             valid_n, step_err_n;
  logic [WRAPW-1:0] wrap_n;
  logic [ERRW-1:0]  err_n;

  count_sync_filter #(.WIDTH(WIDTH), .STABLE(STABLE)) u_filter (
    .clk        (clk),
    .clear      (clear),
    .cnt_in     (cnt_in),
    .s2_next    (cand),
    .stable_hit (stable_hit)
  );

  always_comb begin
    state_n    = state;
    value_n    = value;
    valid_n    = 1'b0;
    step_err_n = 1'b0;
    wrap_n     = wrap_cnt;
    err_n      = err_cnt;
    delta      = cand - value;
    is_up      = (delta == WIDTH'(1));
    is_dn      = (delta == {WIDTH{1'b1}});
    // a steady candidate equal to value is not re-accepted once tracking
    accept     = stable_hit && enable && (state == ST_IDLE || cand != value);
    if (accept) begin
      value_n = cand;
      valid_n = 1'b1;
      case (state)
        ST_IDLE:  state_n = ST_TRACK;
        ST_TRACK: begin
          if (is_up)      state_n = ST_UP;
          else if (is_dn) state_n = ST_DOWN;
          else            step_err_n = 1'b1;
        end
        ST_UP: begin
          if (is_up) begin
            if (value == {WIDTH{1'b1}}) wrap_n = wrap_cnt + 1'b1;
          end else if (is_dn) begin
            step_err_n = 1'b1;
            state_n    = ST_DOWN;
          end else begin
            step_err_n = 1'b1;
            state_n    = ST_TRACK;
          end
        end
        ST_DOWN: begin
          if (is_dn) begin
            if (value == '0) wrap_n = wrap_cnt + 1'b1;
          end else if (is_up) begin
            step_err_n = 1'b1;
            state_n    = ST_UP;
          end else begin
            step_err_n = 1'b1;
            state_n    = ST_TRACK;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (step_err_n && err_cnt != {ERRW{1'b1}}) err_n = err_cnt + 1'b1;
    end
  end

  always_comb begin
    case (state)
      ST_UP:   dir = DIR_UP;
      ST_DOWN: dir = DIR_DOWN;
      default: dir = DIR_UNK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= ST_IDLE;
      value    <= '0;
      valid    <= 1'b0;
      step_err <= 1'b0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      value    <= value_n;
      valid    <= valid_n;
      step_err <= step_err_n;
      wrap_cnt <= wrap_n;
      err_cnt  <= err_n;
    end
  end

endmodule

// File: doc/ripple_count_checker.md
Name: ripple_count_checker

Overview:
- Downstream consumer of the 4-bit asynchronous (ripple) T-flip-flop counter output.
- Samples the rippling count into the `clk` domain through a 2-flop synchronizer and filters transient ripple states with a stability window.
- Tracks count direction, counts wrap-arounds, and flags any accepted step that is not ±1.
- Gives benches and downstream logic a clean, validated count stream.

Parameters:
- WIDTH, 4, width of monitored count.
- STABLE, 2, consecutive edges a synchronized value must hold before acceptance (≥1).
- WRAPW, 8, width of wrap counter.
- ERRW, 8, width of error counter (saturating).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clear  in  1  reset, synchronous, active-high; has priority over everything.
- enable  in  1  when low, acceptance is suppressed and the FSM/counters are frozen; the synchronizer keeps running.
- cnt_in  in  WIDTH  raw ripple-counter output (may glitch).
- value  out  WIDTH  last accepted count.
- valid  out  1  one-cycle pulse on each accepted new value.
- dir  out  2  direction: 00 unknown, 01 up, 10 down.
- step_err  out  1  one-cycle pulse, coincident with `valid`, on an illegal step.
- wrap_cnt  out  WRAPW  number of legal wraps (max→0 up, 0→max down); wraps modulo 2^WRAPW.
- err_cnt  out  ERRW  number of `step_err` pulses; saturates at all-ones.

Behaviour:
- Reset (`clear`=1 at posedge):
  - s1, s2, stability count, `value` = 0.
  - `valid`, `step_err` = 0; `dir` = 00; `wrap_cnt`, `err_cnt` = 0; state = IDLE.
- Synchronizer: s1 <= cnt_in; s2 <= s1.
- Stability count k:
  - k = 1 on the edge s2 loads a value different from its previous value.
  - Otherwise k increments, saturating at STABLE.
- Acceptance: at the edge where k becomes STABLE, with `enable`=1 and (state = IDLE or s2 ≠ `value`):
  - `value` <= s2 and `valid` = 1 for that cycle.
  - Latency from a cnt_in change held steady to `valid`: STABLE+1 edges (3 for STABLE=2).
  - A cnt_in pulse shorter than STABLE cycles is never accepted.
- Step: delta = new − `value` modulo 2^WIDTH. Up = delta 1; down = delta all-ones; anything else is illegal.
- FSM states: IDLE, TRACK, UP, DOWN.
  - IDLE: first acceptance loads `value`, no step check, → TRACK, `dir` 00.
  - TRACK: up → UP (`dir` 01); down → DOWN (`dir` 10); illegal → `step_err`, stay TRACK.
  - UP:
    - up → stay; if `value` was max and new is 0, `wrap_cnt`++.
    - down → `step_err`, → DOWN, `dir` 10.
    - illegal → `step_err`, → TRACK, `dir` 00.
  - DOWN: mirror of UP; wrap is 0→max.
- Every `step_err` increments `err_cnt` (saturating). `valid` and `step_err` fall after one cycle.
- `enable`=0:
  - No acceptance; `valid`/`step_err` held 0; all other outputs are held.
  - Stability count continues, so on re-enable a value already stable for STABLE edges is accepted at the next edge.
- `clear` mid-stream: all outputs return to reset values at that edge; the next accepted value is treated as first (IDLE), so no error is raised.
- Simultaneous `clear` and an acceptance edge: `clear` wins.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, TRACK=1, UP=2, DOWN=3);
  - DIR_UNK/DIR_UP/DIR_DOWN constants;
  - default widths.
- Sub-module `count_sync_filter`:
  - contents: 2-flop sync plus stability counter;
  - outputs: s2 and a `stable_hit` strobe;
  - parameters: WIDTH, STABLE.
- The top instantiates `count_sync_filter` and holds the FSM, step arithmetic and counters.

Test Plan:
- Reset/first value: `clear` 2 cycles, then cnt_in=0 held 3 cycles → `valid` pulses 3 edges after the change, `value`=0, `dir`=00, `err_cnt`=0.
- Up count with wrap: cnt_in steps 0..15,0,1, each held 4 cycles → 18 `valid` pulses, `dir`=01 after second value, `wrap_cnt`=1, `err_cnt`=0.
- Ripple glitch filter: `value`=7, cnt_in shows 6 for 1 cycle then 8 held → no `valid` for 6; `valid` with `value`=8, no `step_err`.
- Down count and reversal: 3,2,1,0,15 → `dir`=10, `wrap_cnt`=1; then 0 → `step_err`, `dir`=01, `err_cnt`=1.
- Illegal skip: in UP at `value`=3, cnt_in=5 held → `step_err`, `dir`=00, `err_cnt`+1; 6 held → `dir`=01, no error.
- Enable and clear: `enable`=0 while cnt_in 4→5 → no `valid`; `enable`=1 → `valid` next edge, `value`=5. `clear` one cycle mid-count → all outputs zero; next value accepted with no `step_err`. 300 forced illegal steps → `err_cnt`=255.
